ps2_device_tx: RTL and testbench

Device-side PS/2 byte transmitter. It is the mouse end of the PS/2 link that the mouse transceiver receives from: it generates the PS/2 clock and shifts out one 11-bit frame per request (start bit, 8 data bits LSB first, odd parity, stop). It drives open-drain line enables and aborts on host inhibit. It is used as an on-board mouse emulator for loopback testing of the transceiver and as a bench BFM.

---
 rtl/ps2_device_tx.sv | 158 +++++++++++++++
 tb/tb_ps2_device_tx.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_device_tx.sv
// Device-side PS/2 transmitter: generates the PS/2 clock and shifts out one 11-bit frame per request.
// Lines are open-drain enables; a host clock inhibit seen at the end of a high phase abandons the frame.
module ps2_device_tx #(
  parameter int HALF_PERIOD     = 1666,
  parameter int BUS_IDLE_CYCLES = 2500
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       SEND_BYTE,
  input  logic [7:0] BYTE_TO_SEND,
  output logic       BUSY,
  output logic       BYTE_SENT,
  output logic       ABORTED,
  input  logic       CLK_MOUSE_IN,
  input  logic       DATA_MOUSE_IN,
  output logic       CLK_MOUSE_OE,
  output logic       DATA_MOUSE_OE
);

  localparam int HW = $clog2(HALF_PERIOD);
  localparam int IW = $clog2(BUS_IDLE_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_BUS, S_BIT_HIGH, S_BIT_LOW, S_END_HIGH, S_ABORT
  } state_t;

  state_t        state, state_nxt;
  logic [10:0]   frame, frame_nxt;
  logic [3:0]    bit_idx, bit_idx_nxt;
  logic [HW-1:0] hp_cnt, hp_cnt_nxt;
  logic [IW-1:0] idle_cnt, idle_cnt_nxt;
  logic          clk_oe_nxt, data_oe_nxt, busy_nxt, byte_sent_nxt, aborted_nxt;
  logic [1:0]    clk_sync, data_sync;
  logic          clk_s, data_s, hp_last;

  assign clk_s   = clk_sync[1];
  assign data_s  = data_sync[1];
  assign hp_last = (hp_cnt == HW'(HALF_PERIOD - 1));

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state         <= S_IDLE;
      frame         <= '0;
      bit_idx       <= '0;
      hp_cnt        <= '0;
      idle_cnt      <= '0;
      CLK_MOUSE_OE  <= 1'b0;
      DATA_MOUSE_OE <= 1'b0;
      BUSY          <= 1'b0;
      BYTE_SENT     <= 1'b0;
      ABORTED       <= 1'b0;
      clk_sync      <= '0;
      data_sync     <= '0;
    end else begin
      state         <= state_nxt;
      frame         <= frame_nxt;
      bit_idx       <= bit_idx_nxt;
      hp_cnt        <= hp_cnt_nxt;
      idle_cnt      <= idle_cnt_nxt;
      CLK_MOUSE_OE  <= clk_oe_nxt;
      DATA_MOUSE_OE <= data_oe_nxt;
      BUSY          <= busy_nxt;
      BYTE_SENT     <= byte_sent_nxt;
      ABORTED       <= aborted_nxt;
      clk_sync      <= {clk_sync[0], CLK_MOUSE_IN};
      data_sync     <= {data_sync[0], DATA_MOUSE_IN};
    end
  end

  always_comb begin
    state_nxt     = state;
    frame_nxt     = frame;
    bit_idx_nxt   = bit_idx;
    hp_cnt_nxt    = hp_cnt;
    idle_cnt_nxt  = idle_cnt;
    clk_oe_nxt    = CLK_MOUSE_OE;
    data_oe_nxt   = DATA_MOUSE_OE;
    busy_nxt      = BUSY;
    byte_sent_nxt = 1'b0;
    aborted_nxt   = 1'b0;

    case (state)
      S_IDLE: begin
        if (SEND_BYTE) begin
          frame_nxt    = {1'b1, ~^BYTE_TO_SEND, BYTE_TO_SEND, 1'b0};
          busy_nxt     = 1'b1;
          idle_cnt_nxt = '0;
          state_nxt    = S_WAIT_BUS;
        end
      end
      S_WAIT_BUS: begin
        if (clk_s && data_s) begin
          if (idle_cnt == IW'(BUS_IDLE_CYCLES - 1)) begin
            bit_idx_nxt = '0;
            hp_cnt_nxt  = '0;
            data_oe_nxt = ~frame[0];
            state_nxt   = S_BIT_HIGH;
          end else begin
            idle_cnt_nxt = idle_cnt + 1'b1;
          end
        end else begin
          idle_cnt_nxt = '0;
        end
      end
      S_BIT_HIGH: begin
        if (hp_last) begin
          hp_cnt_nxt = '0;
          // Clock still low after our release means the host is inhibiting.
          if (!clk_s) begin
            clk_oe_nxt  = 1'b0;
            data_oe_nxt = 1'b0;
            aborted_nxt = 1'b1;
            busy_nxt    = 1'b0;
            state_nxt   = S_ABORT;
          end else begin
            clk_oe_nxt = 1'b1;
            state_nxt  = S_BIT_LOW;
          end
        end else begin
          hp_cnt_nxt = hp_cnt + 1'b1;
        end
      end
      S_BIT_LOW: begin
        if (hp_last) begin
          hp_cnt_nxt = '0;
          clk_oe_nxt = 1'b0;
          if (bit_idx == 4'd10) begin
            data_oe_nxt = 1'b0;
            state_nxt   = S_END_HIGH;
          end else begin
            bit_idx_nxt = bit_idx + 4'd1;
            data_oe_nxt = ~frame[bit_idx + 4'd1];
            state_nxt   = S_BIT_HIGH;
          end
        end else begin
          hp_cnt_nxt = hp_cnt + 1'b1;
        end
      end
      S_END_HIGH: begin
        if (hp_last) begin
          hp_cnt_nxt    = '0;
          byte_sent_nxt = 1'b1;
          busy_nxt      = 1'b0;
          state_nxt     = S_IDLE;
        end else begin
          hp_cnt_nxt = hp_cnt + 1'b1;
        end
      end
      S_ABORT: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ps2_device_tx.sv
// Bench for ps2_device_tx: pull-up line model, host monitor sampling data on clock falling edges,
// expected frames queued at stimulus time and popped on BYTE_SENT / ABORTED.
module tb_ps2_device_tx;

  localparam int HP     = 4;
  localparam int IDLE_C = 8;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       SEND_BYTE = 1'b0;
  logic [7:0] BYTE_TO_SEND = 8'h00;
  logic       BUSY, BYTE_SENT, ABORTED, CLK_MOUSE_OE, DATA_MOUSE_OE;
  logic       CLK_MOUSE_IN, DATA_MOUSE_IN;
  logic       host_clk_low = 1'b0;
  logic       host_data_low = 1'b0;

  assign CLK_MOUSE_IN  = ~CLK_MOUSE_OE & ~host_clk_low;
  assign DATA_MOUSE_IN = ~DATA_MOUSE_OE & ~host_data_low;

  ps2_device_tx #(.HALF_PERIOD(HP), .BUS_IDLE_CYCLES(IDLE_C)) dut (
    .CLK(CLK), .RESET(RESET), .SEND_BYTE(SEND_BYTE), .BYTE_TO_SEND(BYTE_TO_SEND),
    .BUSY(BUSY), .BYTE_SENT(BYTE_SENT), .ABORTED(ABORTED),
    .CLK_MOUSE_IN(CLK_MOUSE_IN), .DATA_MOUSE_IN(DATA_MOUSE_IN),
    .CLK_MOUSE_OE(CLK_MOUSE_OE), .DATA_MOUSE_OE(DATA_MOUSE_OE)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [10:0] frame;
    logic        abort;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   falls = 0;
  int   sent_cnt = 0;
  int   abort_cnt = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Host monitor
  logic        prev_clk = 1'b1;
  logic [10:0] got = '0;
  int          nbits = 0;
  exp_t        e;

  always @(negedge CLK) begin
    if (RESET) begin
      nbits    = 0;
      prev_clk = CLK_MOUSE_IN;
    end else begin
      if (prev_clk && !CLK_MOUSE_IN) begin
        got = {DATA_MOUSE_IN, got[10:1]};
        nbits++;
        falls++;
      end
      prev_clk = CLK_MOUSE_IN;
      if (BYTE_SENT || ABORTED) begin
        if (exp_q.size() == 0) begin
          check("unexpected_event", int'({BYTE_SENT, ABORTED}), 0);
        end else begin
          e = exp_q.pop_front();
          check("event_kind", int'(ABORTED), int'(e.abort));
          if (BYTE_SENT) begin
            check("frame_bit_count", nbits, 11);
            check("frame_bits", int'(got), int'(e.frame));
            check("busy_with_sent", int'(BUSY), 0);
            sent_cnt++;
          end else begin
            check("abort_lines", int'({CLK_MOUSE_OE, DATA_MOUSE_OE}), 0);
            abort_cnt++;
          end
        end
        nbits = 0;
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic strobe(input logic [7:0] b);
    SEND_BYTE    = 1'b1;
    BYTE_TO_SEND = b;
    tick();
    SEND_BYTE = 1'b0;
  endtask

  task automatic expect_frame(input logic [7:0] b, input logic par, input logic abort);
    exp_t x;
    x.frame = {1'b1, par, b, 1'b0};
    x.abort = abort;
    exp_q.push_back(x);
  endtask

  task automatic wait_done(input string name);
    int c = 0;
    while (BUSY && c < 2000) begin
      tick();
      c++;
    end
    check(name, int'(BUSY), 0);
    repeat (3) tick();
  endtask

  task automatic wait_falls(input int base, input int n, input logic oe, input string name);
    int c = 0;
    while (!((falls - base) >= n && CLK_MOUSE_OE == oe) && c < 1000) begin
      tick();
      c++;
    end
    check(name, int'(c < 1000), 1);
  endtask

  logic [7:0] t2_byte [3] = '{8'h00, 8'h01, 8'hFF};
  logic       t2_par  [3] = '{1'b1, 1'b0, 1'b1};

  initial begin
    int lat;
    int base;
    int snap;
    logic seen;

    repeat (3) tick();
    RESET = 1'b0;
    check("reset_outputs", int'({BUSY, BYTE_SENT, ABORTED, CLK_MOUSE_OE, DATA_MOUSE_OE}), 0);
    repeat (5) tick();

    // 1: 0xFA on idle bus, first falling edge 1+8+4 cycles after strobe
    expect_frame(8'hFA, 1'b1, 1'b0);
    strobe(8'hFA);
    check("t1_busy", int'(BUSY), 1);
    lat = 1;
    while (!CLK_MOUSE_OE && lat < 300) begin
      tick();
      lat++;
    end
    check("t1_first_fall", lat, 13);
    wait_done("t1_done");

    // 2: parity sweep
    for (int i = 0; i < 3; i++) begin
      expect_frame(t2_byte[i], t2_par[i], 1'b0);
      strobe(t2_byte[i]);
      wait_done("t2_done");
    end

    // 3: host inhibits clock in the high phase of bit 3
    expect_frame(8'h96, 1'b1, 1'b1);
    base = falls;
    snap = sent_cnt;
    strobe(8'h96);
    wait_falls(base, 3, 1'b0, "t3_reach_bit3");
    host_clk_low = 1'b1;
    lat = 0;
    while (!ABORTED && lat < 100) begin
      tick();
      lat++;
    end
    check("t3_aborted", int'(ABORTED), 1);
    tick();
    check("t3_lines_after", int'({CLK_MOUSE_OE, DATA_MOUSE_OE, BUSY}), 0);
    repeat (3) tick();
    host_clk_low = 1'b0;
    repeat (5) tick();
    check("t3_no_sent", sent_cnt, snap);
    expect_frame(8'h55, 1'b1, 1'b0);
    strobe(8'h55);
    wait_done("t3_retry_done");

    // 4: host holds data low around the strobe
    host_data_low = 1'b1;
    repeat (30) tick();
    expect_frame(8'h81, 1'b1, 1'b0);
    base = falls;
    strobe(8'h81);
    seen = 1'b0;
    repeat (30) begin
      tick();
      seen = seen | CLK_MOUSE_OE;
    end
    check("t4_no_clock_while_held", int'(seen), 0);
    check("t4_no_falls_while_held", falls - base, 0);
    host_data_low = 1'b0;
    lat = 0;
    while (!CLK_MOUSE_OE && lat < 300) begin
      tick();
      lat++;
    end
    check("t4_first_fall", lat, 14);
    wait_done("t4_done");

    // 5: second request mid-frame is ignored
    expect_frame(8'hAB, 1'b0, 1'b0);
    base = falls;
    snap = sent_cnt;
    strobe(8'hAB);
    wait_falls(base, 4, 1'b1, "t5_mid_frame");
    strobe(8'h12);
    wait_done("t5_done");
    repeat (30) tick();
    check("t5_one_sent", sent_cnt - snap, 1);
    check("t5_idle_after", int'(BUSY), 0);

    // 6: reset during the low phase of bit 5
    base = falls;
    strobe(8'hC5);
    wait_falls(base, 6, 1'b1, "t6_reach_bit5");
    RESET = 1'b1;
    tick();
    check("t6_reset_release", int'({CLK_MOUSE_OE, DATA_MOUSE_OE, BUSY}), 0);
    RESET = 1'b0;
    snap = sent_cnt + abort_cnt;
    repeat (10) tick();
    check("t6_no_pulses", sent_cnt + abort_cnt, snap);
    expect_frame(8'h3C, 1'b1, 1'b0);
    strobe(8'h3C);
    wait_done("t6_done");

    check("queue_drained", exp_q.size(), 0);
    check("total_sent", sent_cnt, 8);
    check("total_aborted", abort_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
